cla_share_arbiter: RTL and testbench



---
 rtl/cla_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_cla_share_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cla_share_arbiter
// Brief    : Round-robin sequencer sharing one registered CLA adder among
//            NREQ requesters; results return through a credit-protected FIFO.
//            Optional ARB_STATS_EN macro adds per-requester grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module cla_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_a,
  input  logic [4*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [3:0]           rsp_sum,
  output logic                 rsp_cout
`ifdef ARB_STATS_EN
  ,
  output logic [8*NREQ-1:0]    grant_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic              r_run;
  logic [2:0]        r_ptr;
  logic [2:0]        w_win;
  logic [2:0]        w_ptr_nxt;
  logic [3:0]        w_idx;
  logic              w_any;
  logic              w_credit;
  logic              w_hs;
  logic [7:0]        w_req8;
  logic [31:0]       w_a32;
  logic [31:0]       w_b32;
  logic [ADD_LAT-1:0] r_tag_v;
  logic [2:0]        r_tag_id [ADD_LAT];
  logic [2:0]        w_inflight;
  logic [7:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [7:0]        w_head;

  assign w_req8 = 8'(req_valid);
  assign w_a32  = 32'(req_a);
  assign w_b32  = 32'(req_b);

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_idx = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + 4'(i);
      if (w_idx >= 4'(NREQ)) w_idx = w_idx - 4'(NREQ);
      if (!w_any && w_req8[w_idx[2:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_inflight = 3'd0;
    for (int k = 0; k < ADD_LAT; k++) w_inflight = w_inflight + 3'(r_tag_v[k]);
  end

  // Pops in the current cycle are deliberately not credited; r_run keeps
  // grants off while reset is held so req_ready reads 0 during reset.
  assign w_credit  = (8'(r_count) + 8'(w_inflight)) < 8'(DEPTH);
  assign w_hs      = r_run & w_any & w_credit;
  assign w_ptr_nxt = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) req_ready[i] = w_hs && (w_win == 3'(i));
  end

  assign add_a = w_hs ? w_a32[{w_win, 2'b00} +: 4] : 4'd0;
  assign add_b = w_hs ? w_b32[{w_win, 2'b00} +: 4] : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_ptr   <= 3'd0;
      r_tag_v <= '0;
      for (int k = 0; k < ADD_LAT; k++) r_tag_id[k] <= 3'd0;
    end else begin
      r_run       <= 1'b1;
      if (w_hs) r_ptr <= w_ptr_nxt;
      r_tag_v[0]  <= w_hs;
      r_tag_id[0] <= w_win;
      for (int k = 1; k < ADD_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_push    = r_tag_v[ADD_LAT-1];
  assign w_full    = (r_count == CW'(DEPTH));
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_head    = r_mem[r_rd];
  assign rsp_id    = rsp_valid ? w_head[7:5] : 3'd0;
  assign rsp_sum   = rsp_valid ? w_head[4:1] : 4'd0;
  assign rsp_cout  = rsp_valid ? w_head[0]   : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int d = 0; d < DEPTH; d++) r_mem[d] <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {r_tag_id[ADD_LAT-1], add_s, add_cout};
        r_wr        <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      end
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

`ifdef ARB_STATS_EN
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
      logic [7:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= 8'd0;
        else if (req_valid[g] && req_ready[g] && (r_cnt != 8'hff)) r_cnt <= r_cnt + 8'd1;
      end
      assign grant_cnt[8*g +: 8] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_share_arbiter
// Brief    : Directed self-checking bench for cla_share_arbiter with a
//            registered adder model of ADD_LAT stages.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_share_arbiter;

  localparam int NREQ    = 4;
  localparam int ADD_LAT = 1;
  localparam int DEPTH   = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [4*NREQ-1:0]   req_a = '0;
  logic [4*NREQ-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic [3:0]          add_a;
  logic [3:0]          add_b;
  logic [3:0]          add_s;
  logic                add_cout;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [2:0]          rsp_id;
  logic [3:0]          rsp_sum;
  logic                rsp_cout;
`ifdef ARB_STATS_EN
  logic [8*NREQ-1:0]   grant_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  cla_share_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Registered adder: operands captured on a rising edge, result ADD_LAT edges later.
  logic [4:0] pipe [ADD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ADD_LAT; k++) pipe[k] <= 5'd0;
    end else begin
      pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
      for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign {add_cout, add_s} = pipe[ADD_LAT-1];

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'hF; req_a = 16'hFFFF; req_b = 16'hFFFF;
    #1;
    n_vec++;
    if ({req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b a=%0d b=%0d v=%b id=%0d s=%0d c=%b want all 0",
               req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0001; req_a[3:0] = 4'd5; req_b[3:0] = 4'd7;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001 || add_a !== 4'd5 || add_b !== 4'd7) begin
      n_err++;
      $display("FAIL single_grant: got rdy=%b a=%0d b=%0d want 0001 5 7", req_ready, add_a, add_b);
    end
    @(negedge clk); req_valid = '0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_early: got rsp_valid=%b want 0", rsp_valid);
    end
    @(negedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_sum !== 4'd12 || rsp_cout !== 1'b0) begin
      n_err++;
      $display("FAIL single_rsp: got v=%b id=%0d s=%0d c=%b want 1 0 12 0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_pop: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    int e;
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = 4'(i + 8);
      req_b[4*i +: 4] = 4'd9;
    end
    for (int k = 0; k < 12; k++) begin
      if (k == 10) req_valid = '0;
      #1;
      if (k < 10) begin
        exp_rdy = 4'(1 << (k % 4));
        n_vec++;
        if (req_ready !== exp_rdy || add_a !== 4'((k % 4) + 8)) begin
          n_err++;
          $display("FAIL rr_grant[%0d]: got rdy=%b a=%0d want %b %0d", k, req_ready, add_a, exp_rdy, (k % 4) + 8);
        end
      end
      if (k >= 2) begin
        e = (k - 2) % 4;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'(e) || rsp_sum !== 4'(e + 1) || rsp_cout !== 1'b1) begin
          n_err++;
          $display("FAIL rr_rsp[%0d]: got v=%b id=%0d s=%0d c=%b want 1 %0d %0d 1",
                   k, rsp_valid, rsp_id, rsp_sum, rsp_cout, e, e + 1);
        end
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rr_drained: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    int hs;
    do_reset();
    hs = 0;
    req_valid = 4'b0100; req_a[11:8] = 4'd15; req_b[11:8] = 4'd1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_ready === 4'b0100) hs++;
      @(negedge clk);
    end
    n_vec++;
    if (hs !== DEPTH) begin
      n_err++; $display("FAIL bp_handshakes: got %0d want %0d", hs, DEPTH);
    end
    #1;
    n_vec++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_sum !== 4'd0 || rsp_cout !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full: got rdy=%b v=%b id=%0d s=%0d c=%b want 0000 1 2 0 1",
               req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL bp_pop_not_credited: got rdy=%b want 0000", req_ready);
    end
    @(negedge clk); rsp_ready = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_resume: got rdy=%b want 0100", req_ready);
    end
    @(negedge clk); #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL bp_refull: got rdy=%b want 0000", req_ready);
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_sum !== 4'd0 || rsp_cout !== 1'b1) begin
        n_err++;
        $display("FAIL bp_drain[%0d]: got v=%b id=%0d s=%0d c=%b want 1 2 0 1", j, rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_empty: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_push_pop;
    logic [3:0] exp_s [4];
    exp_s[0] = 4'd2; exp_s[1] = 4'd4; exp_s[2] = 4'd6; exp_s[3] = 4'd8;
    do_reset();
    req_valid = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      req_a[3:0] = 4'(k); req_b[3:0] = 4'(k);
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
    req_valid = 4'b0001; req_a[3:0] = 4'd4; req_b[3:0] = 4'd4;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL pp_grant_at3: got rdy=%b want 0001", req_ready);
    end
    @(negedge clk);
    req_a[3:0] = 4'd5; req_b[3:0] = 4'd5; rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL pp_no_credit: got rdy=%b want 0000", req_ready);
    end
    req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_sum !== exp_s[j] || rsp_cout !== 1'b0) begin
        n_err++;
        $display("FAIL pp_seq[%0d]: got v=%b id=%0d s=%0d c=%b want 1 0 %0d 0", j, rsp_valid, rsp_id, rsp_sum, rsp_cout, exp_s[j]);
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL pp_no_dup: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    req_valid = 4'b0010; req_a[7:4] = 4'd3; req_b[7:4] = 4'd4;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL mid_grant: got rdy=%b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0; rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout} !== 21'd0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got rdy=%b a=%0d b=%0d v=%b id=%0d s=%0d c=%b want all 0",
               req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_no_rsp[%0d]: got rsp_valid=%b want 0", k, rsp_valid);
      end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    req_valid = 4'b0010; rsp_ready = 1'b1; req_a[7:4] = 4'd1; req_b[7:4] = 4'd1;
    repeat (300) @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    n_vec++;
    if (grant_cnt !== 32'h0000_FF00) begin
      n_err++; $display("FAIL stats_cnt: got %h want 0000ff00", grant_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_reset_midflight();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
